// File: rtl/traffic_injector_pkg.sv
// Shared flit format, FSM encoding and flit builder for the traffic injector.
// Field offsets are also used by the router input buffer.
package traffic_injector_pkg;

  localparam int FLIT_W        = 10;
  localparam int DATA_W        = 8;
  localparam int ADDR_W        = 4;
  localparam int FLIT_TYPE_LSB = 8;
  localparam int FLIT_TYPE_W   = 2;
  localparam int FLIT_DATA_LSB = 0;

  typedef enum logic [1:0] {
    FLIT_BODY = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_TAIL = 2'b10
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2,
    ST_TAIL = 2'd3
  } inj_state_e;

  function automatic logic [FLIT_W-1:0] mk_flit(input flit_type_e t, input logic [DATA_W-1:0] p);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[FLIT_TYPE_LSB +: FLIT_TYPE_W] = t;
    f[FLIT_DATA_LSB +: DATA_W]      = p;
    return f;
  endfunction

endpackage

// File: rtl/traffic_injector_if.sv
// Flit valid/ready channel from the injector into the router local input buffer.
interface traffic_injector_if;
  import traffic_injector_pkg::*;

  logic [FLIT_W-1:0] flit_out;
  logic              flit_valid;
  logic              flit_ready;

  modport master (output flit_out, output flit_valid, input flit_ready);
  modport slave  (input flit_out, input flit_valid, output flit_ready);

endinterface

// File: rtl/traffic_inj_flitgen.sv
// Forms head/body/tail flit candidates from the current random byte.
// Destinations equal to this node are flipped in bit 0 so no node targets itself.
module traffic_inj_flitgen
  import traffic_injector_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SRC_ID = 4'd0
) (
  input  logic [DATA_W-1:0] i_rand_in,
  input  logic [DATA_W-1:0] i_tail_tag,
  output logic [FLIT_W-1:0] o_head_flit,
  output logic [FLIT_W-1:0] o_body_flit,
  output logic [FLIT_W-1:0] o_tail_flit
);

  logic [ADDR_W-1:0] w_dst;

  // destination select with self-avoidance
  always_comb begin
    w_dst = i_rand_in[ADDR_W-1:0];
    if (i_rand_in[ADDR_W-1:0] == SRC_ID) begin
      w_dst = i_rand_in[ADDR_W-1:0] ^ 4'h1;
    end else begin
      w_dst = i_rand_in[ADDR_W-1:0];
    end
  end

  assign o_head_flit = mk_flit(FLIT_HEAD, {w_dst, SRC_ID});
  assign o_body_flit = mk_flit(FLIT_BODY, i_rand_in);
  assign o_tail_flit = mk_flit(FLIT_TAIL, i_tail_tag);

endmodule

// File: rtl/traffic_injector.sv
// Packetizes LFSR draws into fixed-length wormhole packets for one router local port.
// Optional macro TRAFFIC_INJ_STALL_CNT_EN adds a saturating back-pressure cycle counter.
module traffic_injector
  import traffic_injector_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SRC_ID  = 4'd0,
  parameter int unsigned       PKT_LEN = 4,
  parameter logic [DATA_W-1:0] RATE    = 8'd64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_enable,
  input  logic [DATA_W-1:0]    i_rand_in,
  output logic                 o_lfsr_en,
  traffic_injector_if.master   flit_if,
  output logic [15:0]          o_pkt_cnt,
`ifdef TRAFFIC_INJ_STALL_CNT_EN
  output logic [15:0]          o_stall_cnt,
`endif
  output logic                 o_busy
);

  localparam logic [3:0] BODY_N = 4'(PKT_LEN - 2);

  inj_state_e        r_state;
  inj_state_e        w_next_state;
  logic [FLIT_W-1:0] r_flit;
  logic              r_flit_valid;
  logic [3:0]        r_body_cnt;
  logic [15:0]       r_pkt_cnt;

  logic              w_accept;
  logic              w_start;
  logic              w_body_more;
  logic              w_lfsr_en;
  logic              w_load_head;
  logic              w_load_body;
  logic              w_load_tail;
  logic              w_done;
  logic [FLIT_W-1:0] w_head_flit;
  logic [FLIT_W-1:0] w_body_flit;
  logic [FLIT_W-1:0] w_tail_flit;

  assign w_accept    = r_flit_valid && flit_if.flit_ready;
  assign w_start     = i_enable && (i_rand_in < RATE);
  assign w_body_more = (r_body_cnt < BODY_N);

  traffic_inj_flitgen #(.SRC_ID(SRC_ID)) u_flitgen (
    .i_rand_in   (i_rand_in),
    .i_tail_tag  (r_pkt_cnt[7:0]),
    .o_head_flit (w_head_flit),
    .o_body_flit (w_body_flit),
    .o_tail_flit (w_tail_flit)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next_state = ST_HEAD;
        else         w_next_state = ST_IDLE;
      end
      ST_HEAD, ST_BODY: begin
        if (w_accept) w_next_state = w_body_more ? ST_BODY : ST_TAIL;
        else          w_next_state = r_state;
      end
      ST_TAIL: begin
        if (w_accept) w_next_state = ST_IDLE;
        else          w_next_state = ST_TAIL;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // per-state load strobes; the LFSR only advances when its byte is consumed
  always_comb begin
    w_lfsr_en   = 1'b0;
    w_load_head = 1'b0;
    w_load_body = 1'b0;
    w_load_tail = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_lfsr_en   = i_enable;
        w_load_head = w_start;
      end
      ST_HEAD, ST_BODY: begin
        w_load_body = w_accept && w_body_more;
        w_load_tail = w_accept && !w_body_more;
        w_lfsr_en   = w_accept && w_body_more;
      end
      ST_TAIL: begin
        w_done = w_accept;
      end
      default: begin
        w_lfsr_en = 1'b0;
      end
    endcase
  end

  // flit register, body counter and packet counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flit       <= '0;
      r_flit_valid <= 1'b0;
      r_body_cnt   <= 4'd0;
      r_pkt_cnt    <= 16'd0;
    end else if (w_load_head) begin
      r_flit       <= w_head_flit;
      r_flit_valid <= 1'b1;
      r_body_cnt   <= 4'd0;
    end else if (w_load_body) begin
      r_flit       <= w_body_flit;
      r_body_cnt   <= r_body_cnt + 4'd1;
    end else if (w_load_tail) begin
      r_flit       <= w_tail_flit;
    end else if (w_done) begin
      r_flit_valid <= 1'b0;
      r_body_cnt   <= 4'd0;
      r_pkt_cnt    <= r_pkt_cnt + 16'd1;
    end
  end

`ifdef TRAFFIC_INJ_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // saturating count of cycles the router holds off a valid flit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= 16'd0;
    end else if (r_flit_valid && !flit_if.flit_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

  assign flit_if.flit_out   = r_flit;
  assign flit_if.flit_valid = r_flit_valid;
  assign o_pkt_cnt          = r_pkt_cnt;
  assign o_busy             = (r_state != ST_IDLE);
  assign o_lfsr_en          = w_lfsr_en;

endmodule
